// File: rtl/axis_i2s_tx_pkg.sv
// Shared frame-layout constants and count-field helpers for the AXI-Stream to I2S transmitter.
// The bit positions describe a 512-clock stereo frame: 64 sclk periods of 8 clocks each.
package axis_i2s_pkg;

   localparam int FRAME_LOG2_DEFAULT = 9;
   localparam int FRAME_CLKS         = 512;
   localparam int SLOTS_PER_CH       = 32;
   localparam int SCLK_DIV_LOG2      = 3;

   localparam int LRCK_BIT = 8;
   localparam int SCLK_BIT = 2;
   localparam int SLOT_LSB = 3;
   localparam int SLOT_MSB = 7;

   typedef logic [FRAME_LOG2_DEFAULT-1:0] count_t;
   typedef logic [SLOT_MSB-SLOT_LSB:0]    slot_t;

   function automatic logic lrck_of(input count_t c);
      return c[LRCK_BIT];
   endfunction

   function automatic logic sclk_of(input count_t c);
      return c[SCLK_BIT];
   endfunction

   function automatic slot_t slot_of(input count_t c);
      return c[SLOT_MSB:SLOT_LSB];
   endfunction

endpackage

// File: rtl/axis_i2s_tx_if.sv
// AXI-Stream sample channel feeding the I2S transmitter; last marks the right-channel word.
interface axis_i2s_tx_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_i2s_tx_frame_timer.sv
// Free-running frame counter producing registered lrck/sclk plus look-ahead slot information
// so the transmitter can register tx_sdout in step with the bit clock.
module i2s_frame_timer
   import axis_i2s_pkg::*;
#(
   parameter int FRAME_LOG2 = FRAME_LOG2_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   output logic  lrck,
   output logic  sclk,
   output logic  frame_start,
   output logic  frame_pre,
   output slot_t next_slot,
   output logic  next_right,
   output logic  next_bit_edge
);

   localparam logic [FRAME_LOG2-1:0] PRE_COUNT = {{(FRAME_LOG2-1){1'b1}}, 1'b0};

   logic [FRAME_LOG2-1:0] count;
   logic [FRAME_LOG2-1:0] count_next;

   assign count_next = count + 1'b1;

   // Registered outputs are computed from the upcoming count so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         lrck  <= 1'b0;
         sclk  <= 1'b0;
      end else begin
         count <= count_next;
         lrck  <= lrck_of(count_next);
         sclk  <= sclk_of(count_next);
      end
   end

   assign frame_start   = (count == '1);
   assign frame_pre     = (count == PRE_COUNT);
   assign next_slot     = slot_of(count_next);
   assign next_right    = lrck_of(count_next);
   assign next_bit_edge = (count_next[SCLK_DIV_LOG2-1:0] == '0);

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream to I2S transmitter: buffers one stereo pair and serializes it MSB first
// with the standard one-bit delay, loading a new pair at every frame boundary.
module axis_i2s_tx
   import axis_i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int FRAME_LOG2 = FRAME_LOG2_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   axis_i2s_tx_if.slave   s_axis,
   output logic           tx_mclk,
   output logic           tx_lrck,
   output logic           tx_sclk,
   output logic           tx_sdout,
   output logic           underrun
);

   localparam slot_t LAST_SLOT = slot_t'(DATA_WIDTH);

   logic                  frame_start;
   logic                  frame_pre;
   slot_t                 next_slot;
   logic                  next_right;
   logic                  next_bit_edge;

   logic [DATA_WIDTH-1:0] left_buf;
   logic [DATA_WIDTH-1:0] right_buf;
   logic                  full;
   logic [DATA_WIDTH-1:0] left_sr;
   logic [DATA_WIDTH-1:0] right_sr;

   logic                  xfer;
   logic                  right_xfer;
   logic                  data_slot;

   i2s_frame_timer #(
      .FRAME_LOG2 (FRAME_LOG2)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .lrck          (tx_lrck),
      .sclk          (tx_sclk),
      .frame_start   (frame_start),
      .frame_pre     (frame_pre),
      .next_slot     (next_slot),
      .next_right    (next_right),
      .next_bit_edge (next_bit_edge)
   );

   assign tx_mclk      = clk;
   assign s_axis.ready = !full && !rst;
   assign xfer         = s_axis.valid && s_axis.ready;
   assign right_xfer   = xfer && s_axis.last;
   assign data_slot    = next_bit_edge && (next_slot != '0) && (next_slot <= LAST_SLOT);

   // Underrun is decided one cycle early so it is visible during the boundary cycle itself;
   // a right word arriving on that boundary cycle is too late for this frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         left_buf  <= '0;
         right_buf <= '0;
         full      <= 1'b0;
         left_sr   <= '0;
         right_sr  <= '0;
         tx_sdout  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (xfer && !s_axis.last)
            left_buf <= s_axis.data;
         if (right_xfer)
            right_buf <= s_axis.data;

         if (right_xfer)
            full <= 1'b1;
         else if (frame_start)
            full <= 1'b0;

         underrun <= frame_pre && !(full || right_xfer);

         if (frame_start) begin
            left_sr  <= full ? left_buf  : '0;
            right_sr <= full ? right_buf : '0;
         end else if (data_slot) begin
            if (next_right)
               right_sr <= right_sr << 1;
            else
               left_sr  <= left_sr << 1;
         end

         if (next_bit_edge)
            tx_sdout <= data_slot ? (next_right ? right_sr[DATA_WIDTH-1] : left_sr[DATA_WIDTH-1]) : 1'b0;
      end
   end

endmodule
